uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver driven by an external oversampling timebase.
//            Both rx and the tick input are synchronized to clk; each rising
//            edge of the tick is one sample event. Bits are sampled at their
//            midpoints and a good frame updates received_byte with a 1-clk
//            rx_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       baud_sample_tick,
  output logic [7:0] received_byte,
  output logic       rx_done
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] C_CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(OVERSAMPLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_meta_q, rx_sync_q;
  logic          tick_meta_q, tick_sync_q, tick_prev_q;
  logic          w_tick_ev;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;

  // Two-flop synchronizers for rx and the tick, plus the tick edge-detect flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      tick_meta_q <= 1'b0;
      tick_sync_q <= 1'b0;
      tick_prev_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      tick_meta_q <= baud_sample_tick;
      tick_sync_q <= tick_meta_q;
      tick_prev_q <= tick_sync_q;
    end
  end

  // One event per tick rising edge, however long the tick stays high
  assign w_tick_ev = tick_sync_q & ~tick_prev_q;

  // Frame FSM: advances only on tick events, samples at bit midpoints
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    if (w_tick_ev) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == C_CNT_HALF) begin
            cnt_d   = '0;
            idx_d   = 3'd0;
            // Line back high at the start-bit midpoint means a glitch
            state_d = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == C_CNT_FULL) begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            cnt_d   = '0;
            if (idx_q == 3'd7) begin
              idx_d   = 3'd0;
              state_d = S_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == C_CNT_FULL) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            // Low stop bit is a framing error: drop the byte silently
            if (rx_sync_q) begin
              byte_d = shift_q;
              done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  assign received_byte = byte_q;
  assign rx_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Randomized scoreboard bench for uart_rx. The driver serializes
//            frames tick by tick and queues the byte each good frame should
//            deliver; a monitor pops on every rx_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       baud;
  logic [7:0] received_byte;
  logic       rx_done;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx               (rx),
    .baud_sample_tick (baud),
    .received_byte    (received_byte),
    .rx_done          (rx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] model_last = 8'h00;
  int         tick_hi = 2;
  int         tick_lo = 4;
  bit         glitch_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One tick event; optional rx glitch well inside the low phase
  task automatic do_tick();
    baud = 1'b1;
    wait_clk(tick_hi);
    baud = 1'b0;
    if (glitch_en && tick_lo >= 20) begin
      wait_clk(8);
      rx = ~rx;
      wait_clk(2);
      rx = ~rx;
      wait_clk(tick_lo - 10);
    end else begin
      wait_clk(tick_lo);
    end
  endtask

  task automatic idle(input int nticks);
    rx = 1'b1;
    repeat (nticks) do_tick();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (OS) do_tick();
  endtask

  // Full frame; a high stop bit queues the byte at its midpoint tick
  task automatic send_frame(input logic [7:0] d, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    rx = stopb;
    for (int k = 0; k < OS; k++) begin
      if (k == OS / 2 && stopb) begin
        sb.push_back('{data: d, cyc: cyc});
        model_last = d;
      end
      do_tick();
    end
  endtask

  // Start bit shorter than half a bit period
  task automatic send_glitch(input int low_ticks);
    rx = 1'b0;
    repeat (low_ticks) do_tick();
    idle(OS);
  endtask

  // Monitor: pop on rx_done, otherwise the output must hold
  initial begin : monitor
    logic [7:0]  exp_hold;
    logic        prev_done;
    exp_t        e;
    int unsigned lat;
    exp_hold  = 8'h00;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_hold  = 8'h00;
        prev_done = 1'b0;
        chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
        chk("reset_byte", {24'd0, received_byte}, 32'd0);
      end else if (rx_done === 1'b1) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_width: rx_done high %0d consecutive clks, expected 1", 2);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rx_done: byte %0h with no frame pending", received_byte);
        end else begin
          e = sb.pop_front();
          chk("rx_byte", {24'd0, received_byte}, {24'd0, e.data});
          lat = cyc - e.cyc;
          checks++;
          if (lat > 4) begin
            errors++;
            $display("FAIL done_latency: got %0d clks expected <= 4", lat);
          end
          exp_hold = e.data;
        end
        prev_done = 1'b1;
      end else begin
        chk("byte_hold", {24'd0, received_byte}, {24'd0, exp_hold});
        prev_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run exceeded time limit, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    logic       stopb;
    int         gap;
    rst  = 1'b0;
    rx   = 1'b1;
    baud = 1'b0;
    wait_clk(5);
    chk("init_byte", {24'd0, received_byte}, 32'd0);
    chk("init_done", {31'd0, rx_done}, 32'd0);
    rst = 1'b1;
    idle(20);

    // Short start glitch: nothing received
    send_glitch(4);
    chk("glitch_byte", {24'd0, received_byte}, 32'd0);

    // Reference frame
    send_frame(8'h96, 1'b1);
    idle(OS);
    chk("byte_96", {24'd0, received_byte}, 32'h96);

    // Framing error keeps the previous byte
    send_frame(8'h5A, 1'b0);
    idle(OS);
    chk("frame_err_byte", {24'd0, received_byte}, 32'h96);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(OS);
    chk("b2b_byte", {24'd0, received_byte}, 32'hFF);

    // Reset in the middle of bit 4, then a clean frame
    d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (OS / 2) do_tick();
    rst = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    rst = 1'b1;
    model_last = 8'h00;
    idle(20);
    chk("abort_byte", {24'd0, received_byte}, 32'h00);
    send_frame(8'hA5, 1'b1);
    idle(OS);
    chk("after_abort_byte", {24'd0, received_byte}, 32'hA5);

    // Long-high square-wave tick with rx glitches between ticks
    tick_hi   = 64;
    tick_lo   = 64;
    glitch_en = 1'b1;
    send_frame(8'h96, 1'b1);
    idle(4);
    tick_hi   = 2;
    tick_lo   = 4;
    glitch_en = 1'b0;
    chk("square_byte", {24'd0, received_byte}, 32'h96);

    // Random frames, gaps, framing errors and start glitches
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 7) == 0) send_glitch($urandom_range(1, 6));
      d     = 8'($urandom);
      stopb = ($urandom_range(0, 5) != 0);
      send_frame(d, stopb);
      gap = stopb ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (gap > 0) idle(gap * OS);
    end

    idle(20);
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("final_byte", {24'd0, received_byte}, {24'd0, model_last});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
